// File: rtl/regacc_pkg.sv
// Shared constants for the register-array access sequencer: op codes, FSM states and defaults.
package regacc_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned KEY_W      = 16;
    localparam int unsigned CNT_W      = 16;

    localparam logic [KEY_W-1:0] KEY_DEF = 16'h0032;

    localparam logic [1:0] OP_ILL   = 2'b00;
    localparam logic [1:0] OP_READ2 = 2'b01;
    localparam logic [1:0] OP_READM = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_access_ctrl.sv
// One-command-at-a-time sequencer for the 1024x32 register/memory array.
// Optional write key check compiled in with REGACC_KEY_CHECK_EN.
module regfile_access_ctrl
    import regacc_pkg::*;
#(
    parameter int unsigned      ADDR_W = ADDR_W_DEF,
    parameter int unsigned      DATA_W = DATA_W_DEF,
    parameter logic [KEY_W-1:0] KEY    = KEY_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_ra,
    input  logic [ADDR_W-1:0] cmd_rb,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data_a,
    output logic [DATA_W-1:0] rsp_data_b,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] rf_reg1,
    output logic [ADDR_W-1:0] rf_reg2,
    output logic [ADDR_W-1:0] rf_address,
    output logic              rf_read_enable,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_read_reg1,
    input  logic [DATA_W-1:0] rf_read_reg2,
    input  logic [DATA_W-1:0] rf_memory_out,
    input  logic [KEY_W-1:0]  rf_key_access,
    output logic [CNT_W-1:0]  wr_count
);

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_data_a_q, rsp_data_a_d;
    logic [DATA_W-1:0]   rsp_data_b_q, rsp_data_b_d;
    logic [ADDR_W-1:0]   rf_reg1_q, rf_reg1_d;
    logic [ADDR_W-1:0]   rf_reg2_q, rf_reg2_d;
    logic [ADDR_W-1:0]   rf_address_q, rf_address_d;
    logic                rf_read_enable_q, rf_read_enable_d;
    logic [DATA_W-1:0]   rf_write_data_q, rf_write_data_d;
    logic [CNT_W-1:0]    wr_count_q, wr_count_d;
    logic                key_ok_c;

`ifdef REGACC_KEY_CHECK_EN
    assign key_ok_c = (rf_key_access == KEY);
`else
    logic key_unused_c;
    assign key_ok_c     = 1'b1;
    assign key_unused_c = ^{rf_key_access, KEY};
`endif

    // Array drive is set up on the accept edge so it is already stable throughout ISSUE.
    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        rsp_valid_d      = rsp_valid_q;
        rsp_err_d        = rsp_err_q;
        rsp_data_a_d     = rsp_data_a_q;
        rsp_data_b_d     = rsp_data_b_q;
        rf_reg1_d        = rf_reg1_q;
        rf_reg2_d        = rf_reg2_q;
        rf_address_d     = rf_address_q;
        rf_write_data_d  = rf_write_data_q;
        rf_read_enable_d = 1'b1;
        wr_count_d       = wr_count_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d = ST_ISSUE;
                    op_d    = cmd_op;
                    case (cmd_op)
                        OP_READ2: begin
                            rf_reg1_d = cmd_ra;
                            rf_reg2_d = cmd_rb;
                        end
                        OP_READM: rf_address_d = cmd_addr;
                        OP_WRITE: begin
                            rf_address_d     = cmd_addr;
                            rf_write_data_d  = cmd_wdata;
                            rf_read_enable_d = ~key_ok_c;
                        end
                        default: ;
                    endcase
                end
            end
            ST_ISSUE: begin
                if (!rf_read_enable_q && (wr_count_q != {CNT_W{1'b1}})) begin
                    wr_count_d = wr_count_q + CNT_W'(1);
                end
                if ((op_q == OP_READ2) || (op_q == OP_READM)) begin
                    state_d = ST_CAPTURE;
                end else begin
                    // A WRITE still holding read_enable high here was rejected by the key check.
                    state_d      = ST_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_err_d    = (op_q == OP_ILL) || rf_read_enable_q;
                    rsp_data_a_d = '0;
                    rsp_data_b_d = '0;
                end
            end
            ST_CAPTURE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                if (op_q == OP_READ2) begin
                    rsp_data_a_d = rf_read_reg1;
                    rsp_data_b_d = rf_read_reg2;
                end else begin
                    rsp_data_a_d = rf_memory_out;
                    rsp_data_b_d = '0;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            op_q             <= OP_ILL;
            cmd_ready_q      <= 1'b1;
            rsp_valid_q      <= 1'b0;
            rsp_err_q        <= 1'b0;
            rsp_data_a_q     <= '0;
            rsp_data_b_q     <= '0;
            rf_reg1_q        <= '0;
            rf_reg2_q        <= '0;
            rf_address_q     <= '0;
            rf_read_enable_q <= 1'b1;
            rf_write_data_q  <= '0;
            wr_count_q       <= '0;
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            cmd_ready_q      <= cmd_ready_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_err_q        <= rsp_err_d;
            rsp_data_a_q     <= rsp_data_a_d;
            rsp_data_b_q     <= rsp_data_b_d;
            rf_reg1_q        <= rf_reg1_d;
            rf_reg2_q        <= rf_reg2_d;
            rf_address_q     <= rf_address_d;
            rf_read_enable_q <= rf_read_enable_d;
            rf_write_data_q  <= rf_write_data_d;
            wr_count_q       <= wr_count_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_err        = rsp_err_q;
    assign rsp_data_a     = rsp_data_a_q;
    assign rsp_data_b     = rsp_data_b_q;
    assign rf_reg1        = rf_reg1_q;
    assign rf_reg2        = rf_reg2_q;
    assign rf_address     = rf_address_q;
    assign rf_read_enable = rf_read_enable_q;
    assign rf_write_data  = rf_write_data_q;
    assign wr_count       = wr_count_q;

endmodule
